// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer
// Shares one memory port between instruction fetch and the data requester.
// Data wins arbitration unless fetch has been passed over STARVE_LIMIT times
// in a row. The winning request is latched, driven to memory until mem_ready
// or a timeout, then answered with a one-cycle done pulse.
//
// Ports
//   clock, reset             rising-edge clock, async active-low reset
//   if_req/if_addr           fetch request (level) and PC
//   if_rdata/if_done         fetched instruction, completion pulse
//   d_req/d_we/d_size/       data request (level), store flag, size,
//   d_addr/d_wdata           address and store data
//   d_rdata/d_done           size-masked load data, completion pulse
//   err                      timeout flag, valid with done
//   mem_*                    shared memory port
//   busy/grant_src           sequencer occupied / 0 = fetch, 1 = data
//
// state  | meaning
// IDLE   | sample requests, arbitrate, latch the winner
// ACCESS | memory port driven, waiting for mem_ready or timeout
// RESP   | one-cycle done pulse to the granted source
module mem_port_sequencer #(
    parameter int AW           = 64,
    parameter int DW           = 64,
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [1:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          grant_src
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // Last ACCESS cycle index before a forced termination.
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

    logic [1:0]    state_q,    state_d;
    logic          src_q,      src_d;
    logic          we_q,       we_d;
    logic [1:0]    size_q,     size_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic [DW-1:0] wdata_q,    wdata_d;
    logic [7:0]    wait_q,     wait_d;
    logic [3:0]    streak_q,   streak_d;
    logic          err_q,      err_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q,  d_rdata_d;

    function automatic logic [DW-1:0] size_mask(input logic [DW-1:0] d,
                                                input logic [1:0]    sz);
        logic [DW-1:0] m;
        m = '0;
        case (sz)
            2'b00:   m[7:0]  = d[7:0];
            2'b01:   m[15:0] = d[15:0];
            2'b10:   m[31:0] = d[31:0];
            default: m       = d;
        endcase
        return m;
    endfunction

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        we_d       = we_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wait_d     = wait_q;
        streak_d   = streak_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (d_req && !(if_req && streak_q == STREAK_MAX)) begin
                    state_d = S_ACCESS;
                    src_d   = 1'b1;
                    we_d    = d_we;
                    size_d  = d_size;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    // Streak only counts grants that actually passed fetch over.
                    if (!if_req)
                        streak_d = '0;
                    else if (streak_q != STREAK_MAX)
                        streak_d = streak_q + 4'd1;
                end else if (if_req) begin
                    state_d  = S_ACCESS;
                    src_d    = 1'b0;
                    we_d     = 1'b0;
                    size_d   = 2'b10;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    streak_d = '0;
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    state_d = S_RESP;
                    err_d   = 1'b0;
                    if (!src_q)
                        if_rdata_d = mem_rdata[31:0];
                    else
                        d_rdata_d = we_q ? '0 : size_mask(mem_rdata, size_q);
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    if (!src_q)
                        if_rdata_d = '0;
                    else
                        d_rdata_d = '0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                wait_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            src_q      <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_q     <= '0;
            streak_q   <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            we_q       <= we_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wait_q     <= wait_d;
            streak_q   <= streak_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Strobes decode straight from the state flop so reset drops them at once.
    assign mem_en    = (state_q == S_ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_size  = size_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign grant_src = src_q;
    assign if_done   = (state_q == S_RESP) & ~src_q;
    assign d_done    = (state_q == S_RESP) & src_q;
    assign err       = (state_q == S_RESP) & err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
module tb_mem_port_sequencer;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          if_done;
    logic          d_req;
    logic          d_we;
    logic [1:0]    d_size;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          err;
    logic          mem_en;
    logic          mem_we;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          busy;
    logic          grant_src;

    int cmp_cnt = 0;
    int err_cnt = 0;

    mem_port_sequencer #(
        .AW(AW), .DW(DW), .TIMEOUT(15), .STARVE_LIMIT(4)
    ) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .grant_src(grant_src)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_size    = 2'b00;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        // reset state
        step();
        step();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_err", err, 0);
        chk("rst_grant_src", grant_src, 0);
        chk("rst_d_rdata", d_rdata, 0);
        reset = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // fetch with two wait cycles
        if_addr = 64'h40;
        if_req  = 1'b1;
        step();
        chk("f_c1_mem_en", mem_en, 1);
        chk("f_c1_addr", mem_addr, 64'h40);
        chk("f_c1_size", mem_size, 2'b10);
        chk("f_c1_we", mem_we, 0);
        chk("f_c1_src", grant_src, 0);
        step();
        chk("f_c2_mem_en", mem_en, 1);
        step();
        chk("f_c3_mem_en", mem_en, 1);
        chk("f_c3_if_done", if_done, 0);
        mem_ready = 1'b1;
        mem_rdata = 64'h0000_0000_8B02_0020;
        step();
        chk("f_c4_if_done", if_done, 1);
        chk("f_c4_if_rdata", if_rdata, 32'h8B02_0020);
        chk("f_c4_err", err, 0);
        chk("f_c4_d_done", d_done, 0);
        chk("f_c4_mem_en", mem_en, 0);
        if_req    = 1'b0;
        mem_ready = 1'b0;
        step();
        chk("f_idle_done", if_done, 0);
        chk("f_idle_busy", busy, 0);

        // byte load with immediate ready
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_size    = 2'b00;
        d_addr    = 64'h1000;
        mem_ready = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFA5;
        step();
        chk("b_c1_mem_en", mem_en, 1);
        chk("b_c1_src", grant_src, 1);
        chk("b_c1_size", mem_size, 2'b00);
        chk("b_c1_addr", mem_addr, 64'h1000);
        step();
        chk("b_c2_d_done", d_done, 1);
        chk("b_c2_d_rdata", d_rdata, 64'h0000_0000_0000_00A5);
        chk("b_c2_src", grant_src, 1);
        chk("b_c2_if_done", if_done, 0);
        d_req = 1'b0;
        step();

        // half load masks to 16 bits
        d_req     = 1'b1;
        d_size    = 2'b01;
        mem_rdata = 64'h1234_5678_9ABC_DEF0;
        step();
        step();
        chk("h_d_done", d_done, 1);
        chk("h_d_rdata", d_rdata, 64'h0000_0000_0000_DEF0);
        d_req = 1'b0;
        step();

        // both requesters continuously: D,D,D,D,F,D,D,D,D,F
        if_req  = 1'b1;
        if_addr = 64'h80;
        d_req   = 1'b1;
        d_size  = 2'b11;
        mem_rdata = 64'h0000_0000_1111_2222;
        for (int g = 0; g < 10; g++) begin
            logic exp_d;
            exp_d = !(g == 4 || g == 9);
            step();
            chk($sformatf("arb%0d_src", g), grant_src, exp_d);
            chk($sformatf("arb%0d_mem_en", g), mem_en, 1);
            step();
            chk($sformatf("arb%0d_if_done", g), if_done, !exp_d);
            chk($sformatf("arb%0d_d_done", g), d_done, exp_d);
            step();
        end
        if_req    = 1'b0;
        d_req     = 1'b0;
        mem_ready = 1'b0;
        step();
        chk("arb_end_busy", busy, 0);

        // store that times out
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_size  = 2'b11;
        d_addr  = 64'h2000;
        d_wdata = 64'hDEAD_BEEF_0BAD_F00D;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("to_c%0d_mem_en", i), mem_en, 1);
            if (i == 1) begin
                chk("to_mem_we", mem_we, 1);
                chk("to_mem_wdata", mem_wdata, 64'hDEAD_BEEF_0BAD_F00D);
            end
        end
        step();
        chk("to_mem_en_drop", mem_en, 0);
        chk("to_d_done", d_done, 1);
        chk("to_err", err, 1);
        chk("to_d_rdata", d_rdata, 0);
        d_req = 1'b0;
        step();
        chk("to_err_clear", err, 0);

        // normal word load right after the timeout
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_size    = 2'b10;
        mem_ready = 1'b1;
        mem_rdata = 64'hCAFE_BABE_1234_5678;
        step();
        step();
        chk("after_to_d_done", d_done, 1);
        chk("after_to_err", err, 0);
        chk("after_to_d_rdata", d_rdata, 64'h0000_0000_1234_5678);
        d_req     = 1'b0;
        mem_ready = 1'b0;
        step();

        // ready on the 15th wait cycle beats the timeout
        d_req     = 1'b1;
        d_size    = 2'b11;
        mem_rdata = 64'h0123_4567_89AB_CDEF;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("edge_c%0d_mem_en", i), mem_en, 1);
            if (i == 15) mem_ready = 1'b1;
        end
        step();
        chk("edge_d_done", d_done, 1);
        chk("edge_err", err, 0);
        chk("edge_d_rdata", d_rdata, 64'h0123_4567_89AB_CDEF);
        d_req     = 1'b0;
        mem_ready = 1'b0;
        step();

        // asynchronous reset in the middle of an access
        d_req = 1'b1;
        step();
        chk("ar_mem_en_before", mem_en, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_mem_en", mem_en, 0);
        chk("ar_busy", busy, 0);
        chk("ar_d_done", d_done, 0);
        chk("ar_d_rdata", d_rdata, 0);
        d_req = 1'b0;
        #2 reset = 1'b1;
        step();
        step();
        chk("ar_idle_busy", busy, 0);
        chk("ar_idle_mem_en", mem_en, 0);
        chk("ar_idle_if_rdata", if_rdata, 0);
        chk("ar_idle_d_done", d_done, 0);
        chk("ar_idle_if_done", if_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_port_sequencer.md
Name: mem_port_sequencer

Overview:
- Sequences the single shared memory port between the instruction-fetch requester (IF state, IL) and the data requester (LDUR/STUR in EX states).
- Arbitrates between the two, latches the request, and holds the memory interface until the memory signals ready or a timeout fires.
- Returns read data with a one-cycle done pulse to the winner, so the control unit can stall its state register on busy.

Parameters:
- AW, 64, address width.
- DW, 64, memory data width.
- TIMEOUT, 15, maximum wait cycles in ACCESS before forced termination (1..255).
- STARVE_LIMIT, 4, consecutive data grants while if_req is pending, after which fetch wins (1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- if_req  in  1  fetch request, level; held until if_done.
- if_addr  in  AW  fetch address (PC).
- if_rdata  out  32  fetched instruction.
- if_done  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request, level; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data, zero-extended per size.
- d_done  out  1  one-cycle completion pulse for data.
- err  out  1  timeout flag, valid with done.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_size  out  2  access size.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory completes the access this cycle.
- busy  out  1  high in ACCESS and RESP.
- grant_src  out  1  0 = fetch, 1 = data; meaningful while busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0; wait counter, streak counter and capture registers 0.
  - Any in-flight memory access is abandoned; mem_en drops without waiting for the clock.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled only here.
  - If d_req=1 and not (if_req=1 and streak==STARVE_LIMIT): grant data, streak += 1 if if_req=1 (saturating), else streak=0.
  - Else if if_req=1: grant fetch, streak=0.
  - On a grant, latch addr/we/size/wdata (fetch: we=0, size=10) and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - mem_en=1, and mem_we/size/addr/wdata are driven from the latched registers, stable for the whole state.
  - Changes on the request inputs are ignored.
  - Wait counter increments each cycle with mem_ready=0.
  - mem_ready=1: capture mem_rdata, err=0, go to RESP.
  - Counter reaches TIMEOUT with mem_ready=0: captured data=0, err=1, go to RESP.
  - mem_ready in the same cycle as the timeout: ready wins, err=0.
- RESP (exactly one cycle):
  - mem_en=0; done pulses for the granted source only.
  - if_rdata = captured[31:0].
  - d_rdata = captured data masked to d_size (byte [7:0], half [15:0], word [31:0], dword all), upper bits 0.
  - Stores return d_rdata=0.
  - err is valid this cycle only.
  - Always returns to IDLE; wait counter cleared.
- Requester rule: deassert req on the clock edge ending the done cycle, so req is low in the following IDLE cycle; req still high in IDLE is a new request.
- Latency:
  - Request high in IDLE at cycle 0 → mem_en at cycle 1.
  - If mem_ready at cycle 1+n → done at cycle 2+n.
  - Minimum 2 cycles to done; throughput 1 access per 3 cycles.
- Data outputs (if_rdata, d_rdata) hold their last values outside RESP; consumers qualify them with done.
- Data has priority over fetch; the streak counter guarantees fetch service at least once every STARVE_LIMIT+1 grants.

Test Plan:
- Reset: hold reset=0 mid-ACCESS with mem_en=1 → mem_en, busy, dones drop without waiting for a clock edge; after release with no requests, state stays IDLE and all outputs are 0.
- Fetch: if_req=1, if_addr=0x40, mem_ready after 2 wait cycles with mem_rdata=0x00000000_8B020020 → mem_en cycles 1–3, mem_size=10, mem_we=0; if_done at cycle 4 with if_rdata=0x8B020020, err=0.
- Byte load: d_req=1, d_we=0, d_size=00, d_addr=0x1000, immediate ready, mem_rdata=0xFFFF_FFFF_FFFF_FFA5 → d_done at cycle 2 with d_rdata=0x0000_0000_0000_00A5, grant_src=1.
- Simultaneous requests: if_req and d_req both high continuously with STARVE_LIMIT=4 and immediate ready → grant sequence D,D,D,D,F,D,D,D,D,F; if_done only on fetch grants.
- Timeout: d_req store with mem_ready stuck 0, TIMEOUT=15 → mem_en high 15 cycles then drops; d_done=1 with err=1, d_rdata=0; next request is serviced normally.
- Ready at timeout edge: mem_ready=1 on the 15th wait cycle → err=0 and the data is captured.
